mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one single-port 16-bit data/program RAM between three requesters: host loader (0),
//  processor data load/store (1), processor instruction fetch (2). One transaction at a time.
//  Sits between processor_verilog's memory ports and the RAM; serialises all accesses.
// PARAMETERS
//  NUM_REQ      3   number of requesters (fixed at 3 in this revision)
//  ADDR_W       16  address width
//  DATA_W       16  data width
//  MEM_LATENCY  1   RAM read latency in cycles from mem_en sample to mem_rdata valid (>=1)
// PORTS
//  clk           in   1               system clock, all logic on posedge
//  reset         in   1               synchronous, active-high
//  req           in   NUM_REQ         per-requester request, level
//  req_we        in   NUM_REQ         per-requester write enable
//  req_addr      in   NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata     in   NUM_REQ*DATA_W  packed write data, same packing
//  gnt           out  NUM_REQ         one-hot, one-cycle grant pulse
//  rvalid        out  NUM_REQ         one-hot, one-cycle completion pulse (reads and writes)
//  rdata         out  DATA_W          read data, valid while rvalid is set
//  mem_en        out  1               RAM access strobe, one cycle per transaction
//  mem_we        out  1               RAM write enable, qualified by mem_en
//  mem_addr      out  ADDR_W          RAM address
//  mem_wdata     out  DATA_W          RAM write data
//  mem_rdata     in   DATA_W          RAM read data
//  state_output  out  2               current FSM state, debug
// BEHAVIOUR
//  - All outputs registered. On reset: gnt=0, rvalid=0, rdata=0, mem_en=0, mem_we=0,
//    mem_addr=0, mem_wdata=0, state=IDLE, RR pointer=0, latency counter=0.
//  - States: IDLE(0) -> ISSUE(1) -> WAIT(2) -> RESP(3) -> IDLE.
//  - IDLE: if any req bit is set at an edge, winner w is chosen, gnt[w]<=1, mem_en<=1,
//    mem_we/addr/wdata<=requester w's fields; -> ISSUE. No req: stay, outputs idle.
//  - ISSUE: gnt and mem_en high this cycle; at edge drop both, load counter=MEM_LATENCY-1; -> WAIT.
//  - WAIT: decrement counter; at count 0 sample mem_rdata into rdata, rvalid[w]<=1; -> RESP.
//  - RESP: rvalid high this cycle; at edge clear rvalid; -> IDLE.
//  - Writes follow the same sequence; rdata is then loaded with mem_rdata as read by the RAM
//    (don't-care to requester). rvalid means "write committed".
//  - Latency: gnt rises 1 cycle after req sampled; rvalid rises MEM_LATENCY+1 cycles after gnt.
//    Throughput: one transaction per MEM_LATENCY+3 cycles.
//  - Requester holds req/we/addr/wdata stable until gnt; fields are captured at the IDLE edge.
//    Req still high when FSM next reaches IDLE is a new request.
//  - Requests arriving outside IDLE are not lost as long as req stays high; they are not queued.
//  - Simultaneous requests: resolved by the selected policy; exactly one gnt bit ever set.
//  - Reset mid-transaction: FSM to IDLE next edge; pending rvalid is discarded, not issued.
//  - Read data: rdata holds its last value until the next RESP load.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: round-robin arbitration. Search starts at pointer p, p=(w+1)%NUM_REQ
//    after each grant. Pointer updates on the IDLE->ISSUE edge.
//  ARB_ROUND_ROBIN_EN undefined: fixed priority loader(0) > data(1) > fetch(2). Pointer logic absent.
// STRUCTURE
//  - Shared package mem_arb_pkg: state encodings ST_IDLE/ST_ISSUE/ST_WAIT/ST_RESP and requester
//    indices REQ_LOADER=0, REQ_DATA=1, REQ_FETCH=2.
//  - One sub-module arb_picker: combinational req + pointer -> one-hot winner. Pointer input is
//    tied to 0 when ARB_ROUND_ROBIN_EN is undefined.
//  - FSM, latency counter and output registers live in mem_bus_arbiter.
// TESTING
//  1 Reset: hold reset 2 cycles with req=3'b111 -> all outputs 0, state_output=0 throughout.
//  2 Single read: req[2], addr=0x0010, RAM[0x10]=0xBEEF, MEM_LATENCY=1 -> gnt=3'b100 one cycle
//    after sample, mem_addr=0x0010, rvalid=3'b100 two cycles after gnt, rdata=0xBEEF.
//  3 Write then read: req[1] writes 0x1234 to 0x0020, then reads 0x0020 -> mem_we=1 once;
//    second rvalid carries rdata=0x1234.
//  4 Contention, fixed priority (macro off): req=3'b111 held -> grants 001,001,001... and
//    requesters 1/2 starve while 0 holds req.
//  5 Contention, RR (macro on): req=3'b111 held -> grant order 001,010,100,001. Gap between
//    grants is exactly MEM_LATENCY+3 cycles.
//  6 Reset in WAIT: assert reset during WAIT of a read -> no rvalid pulse; IDLE next cycle;
//    a new req is granted normally afterwards.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encodings and requester indices for the memory bus arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int REQ_LOADER = 0;
    localparam int REQ_DATA   = 1;
    localparam int REQ_FETCH  = 2;

    // Round-robin pointer after a grant: one past the winner, wrapping at three requesters.
    function automatic logic [1:0] rr_next_ptr(input logic [2:0] onehot);
        logic [1:0] p;
        p = 2'd0;
        if (onehot[REQ_LOADER]) p = 2'd1;
        if (onehot[REQ_DATA])   p = 2'd2;
        if (onehot[REQ_FETCH])  p = 2'd0;
        return p;
    endfunction

endpackage

// File: rtl/arb_picker.sv
// rtl/arb_picker.sv - combinational one-hot winner select, search starting at i_ptr
module arb_picker #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_any
);

    always_comb begin : p_pick
        logic [PTR_W-1:0] idx;
        o_gnt = '0;
        o_any = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_any && i_req[idx]) begin
                o_gnt[idx] = 1'b1;
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - serialises three requesters onto one single-port RAM
// ARB_ROUND_ROBIN_EN selects round-robin arbitration; undefined gives fixed priority 0 > 1 > 2.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [1:0]                state_output
);

    localparam int PTR_W = 2;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_t              r_state, w_state_nxt;
    logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
    logic [NUM_REQ-1:0]  r_rvalid, w_rvalid_nxt;
    logic [NUM_REQ-1:0]  r_owner, w_owner_nxt;
    logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
    logic                r_mem_en, w_mem_en_nxt;
    logic                r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;

    logic [NUM_REQ-1:0]  w_pick;
    logic                w_any;
    logic [PTR_W-1:0]    w_ptr;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

`ifdef ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0]    r_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (r_state == ST_IDLE && w_any) begin
            r_ptr <= rr_next_ptr(w_pick);
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    arb_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .i_req (req),
        .i_ptr (w_ptr),
        .o_gnt (w_pick),
        .o_any (w_any)
    );

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) begin
                w_sel_we    = req_we[i];
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = '0;
        w_rvalid_nxt    = '0;
        w_owner_nxt     = r_owner;
        w_rdata_nxt     = r_rdata;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_cnt_nxt       = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt     = ST_ISSUE;
                    w_gnt_nxt       = w_pick;
                    w_owner_nxt     = w_pick;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = w_sel_we;
                    w_mem_addr_nxt  = w_sel_addr;
                    w_mem_wdata_nxt = w_sel_wdata;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = CNT_W'(MEM_LATENCY - 1);
            end
            ST_WAIT: begin
                // Writes also load rdata; the requester ignores it on a write completion.
                if (r_cnt == '0) begin
                    w_state_nxt  = ST_RESP;
                    w_rdata_nxt  = mem_rdata;
                    w_rvalid_nxt = r_owner;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_owner     <= '0;
            r_rdata     <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_rvalid    <= w_rvalid_nxt;
            r_owner     <= w_owner_nxt;
            r_rdata     <= w_rdata_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign gnt          = r_gnt;
    assign rvalid       = r_rvalid;
    assign rdata        = r_rdata;
    assign mem_en       = r_mem_en;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign state_output = r_state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter with a transaction-level model
module tb_mem_bus_arbiter;

    localparam int L  = 1;
    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic [1:0]      state_output;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .NUM_REQ     (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MEM_LATENCY (L)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .state_output (state_output)
    );

    function automatic logic [15:0] init_word(input int a);
        if (a == 16) return 16'hBEEF;
        return 16'(a * 257) ^ 16'h5A5A;
    endfunction

    // RAM with one-cycle read latency; contents seeded on the first edge.
    logic [15:0] ram [0:255];
    bit          ram_ready = 0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            mem_rdata <= '0;
            ram_ready <= 1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
            mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp, input int c);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, c, act, exp);
    endtask

    // Reference model: transaction-level arbiter behaviour.
    typedef struct {
        int          due;
        logic [2:0]  who;
        logic        wr;
        logic [15:0] data;
    } exp_t;

    exp_t        q[$];
    logic [15:0] mdl [0:255];
    bit          mdl_ready = 0;
    int          cyc = 0;
    int          next_free = 0;
    int          ptr = 0;
    logic        p_reset = 1'b1;
    logic [2:0]  p_req = '0;
    logic [2:0]  p_we = '0;
    logic [47:0] p_addr = '0;
    logic [47:0] p_wdata = '0;

    function automatic int pick(input logic [2:0] r, input int p);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 3; k++) if (r[(p + k) % 3]) return (p + k) % 3;
`else
        for (int i = 0; i < 3; i++) if (r[i]) return i;
`endif
        return 0;
    endfunction

    always @(negedge clk) begin
        logic [2:0]  exp_g;
        logic [2:0]  exp_rv;
        logic [15:0] a;
        logic [15:0] d;
        int          w;
        exp_t        e;
        cyc++;
        if (!mdl_ready) begin
            for (int i = 0; i < 256; i++) mdl[i] = init_word(i);
            mdl_ready = 1;
        end
        if (p_reset) begin
            q.delete();
            next_free = cyc + 1;
            ptr = 0;
            chk("rst_ctrl", {gnt, rvalid, mem_en, mem_we, state_output}, '0, cyc);
            chk("rst_data", {rdata, mem_addr, mem_wdata}, '0, cyc);
        end else begin
            exp_g = '0;
            if (cyc >= next_free && p_req != 3'b000) begin
                w = pick(p_req, ptr);
                exp_g = 3'(1 << w);
`ifdef ARB_ROUND_ROBIN_EN
                ptr = (w + 1) % 3;
`endif
                next_free = cyc + L + 3;
                a = p_addr[w*16 +: 16];
                d = p_wdata[w*16 +: 16];
                e.due = cyc + L + 1;
                e.who = exp_g;
                e.wr  = p_we[w];
                e.data = p_we[w] ? d : mdl[a[7:0]];
                if (p_we[w]) mdl[a[7:0]] = d;
                q.push_back(e);
                chk("mem_addr", mem_addr, a, cyc);
                chk("mem_we", mem_we, p_we[w], cyc);
                if (p_we[w]) chk("mem_wdata", mem_wdata, d, cyc);
                chk("state_issue", state_output, 2'd1, cyc);
            end
            chk("gnt", gnt, exp_g, cyc);
            chk("mem_en", mem_en, exp_g != 3'b000, cyc);
            exp_rv = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                exp_rv = e.who;
                if (!e.wr) chk("rdata", rdata, e.data, cyc);
                chk("state_resp", state_output, 2'd3, cyc);
            end
            chk("rvalid", rvalid, exp_rv, cyc);
        end
        p_reset = reset;
        p_req   = req;
        p_we    = req_we;
        p_addr  = req_addr;
        p_wdata = req_wdata;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_fields(input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
        req_we[i] = we;
        req_addr[i*16 +: 16] = a;
        req_wdata[i*16 +: 16] = d;
    endtask

    // Raise one request and hold it until granted; returns in the ISSUE cycle.
    task automatic do_req(input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
        bit seen;
        seen = 0;
        set_fields(i, we, a, d);
        req[i] = 1'b1;
        for (int t = 0; t < 50 && !seen; t++) begin
            step();
            if (gnt[i]) seen = 1;
        end
        chk("gnt_seen", seen, 1, cyc);
        req[i] = 1'b0;
    endtask

    initial begin
        // Reset held two edges with all requests raised.
        reset = 1'b1;
        req = 3'b111;
        step();
        step();
        reset = 1'b0;
        req = 3'b000;
        repeat (2) step();

        do_req(2, 1'b0, 16'h0010, 16'h0000);
        repeat (4) step();

        do_req(1, 1'b1, 16'h0020, 16'h1234);
        do_req(1, 1'b0, 16'h0020, 16'h0000);
        repeat (5) step();

        // Contention with every requester holding its line.
        set_fields(0, 1'b0, 16'h0001, 16'h0);
        set_fields(1, 1'b0, 16'h0002, 16'h0);
        set_fields(2, 1'b0, 16'h0003, 16'h0);
        req = 3'b111;
        repeat (12 * (L + 3)) step();
        req = 3'b000;
        repeat (5) step();

        // Reset while a read sits in WAIT.
        do_req(0, 1'b0, 16'h0030, 16'h0000);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        do_req(2, 1'b0, 16'h0010, 16'h0000);
        repeat (5) step();

        for (int t = 0; t < 800; t++) begin
            reset = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < N; i++) begin
                if (req[i] && gnt[i]) req[i] = 1'b0;
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    set_fields(i, (i != 2) && $urandom_range(0, 1) == 1,
                               16'($urandom_range(0, 15)), 16'($urandom));
                    req[i] = 1'b1;
                end
            end
            step();
        end
        reset = 1'b0;
        req = 3'b000;
        repeat (10) step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
